// File: rtl/seq_datapath_if.sv
// Single shared memory port used for both instruction fetch and data access.
interface seq_datapath_if #(
  parameter int unsigned WIDTH = 16
);
  logic             mem_req;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/seq_datapath.sv
// Multicycle 16-bit-instruction datapath: FETCH/DECODE/EXEC/MEM/WB over one
// memory port, with a register file, ALU and {N,Z,F,L,C} status flags.
module seq_datapath #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREGS = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  seq_datapath_if.master    mem,
  output logic [WIDTH-1:0]  pc,
  output logic [4:0]        psr_flags,
  output logic [2:0]        state
);

  localparam int unsigned IW = 16;
  localparam int unsigned FN = 4;
  localparam int unsigned FZ = 3;
  localparam int unsigned FF = 2;
  localparam int unsigned FL = 1;
  localparam int unsigned FC = 0;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [IW-1:0]    r_ir;
  logic [WIDTH-1:0] r_pc, r_a, r_b, r_imm, r_aluout, r_mdr;
  logic [4:0]       r_flags;
  logic             r_mem_req, r_mem_we;
  logic [WIDTH-1:0] r_mem_addr, r_mem_wdata;
  logic [WIDTH-1:0] r_regs [NREGS];

  logic [3:0]       w_op, w_rd, w_ext, w_rs;
  logic             w_is_add, w_is_sub, w_is_cmp, w_is_alu;
  logic             w_is_load, w_is_stor, w_is_jump, w_is_br, w_br_taken;
  logic [WIDTH-1:0] w_opb, w_alu_res, w_ra, w_rb, w_wb_data;
  logic [WIDTH:0]   w_sum, w_diff;
  logic [4:0]       w_flags_exec, w_flags_nxt;
  logic [WIDTH-1:0] w_pc_nxt, w_aluout_nxt;
  logic             w_rf_we;
  state_t           w_done;

  assign w_op  = r_ir[15:12];
  assign w_rd  = r_ir[11:8];
  assign w_ext = r_ir[7:4];
  assign w_rs  = r_ir[3:0];

  assign w_is_add  = (w_op == 4'h0 && w_ext == 4'h5) || w_op == 4'h5;
  assign w_is_sub  = (w_op == 4'h0 && w_ext == 4'h9) || w_op == 4'h9;
  assign w_is_cmp  = (w_op == 4'h0 && w_ext == 4'hB) || w_op == 4'hB;
  assign w_is_alu  = (w_op == 4'h0 && (w_ext inside {4'h5, 4'h9, 4'h1, 4'h2, 4'h3, 4'hD}))
                   || (w_op inside {4'h5, 4'h9, 4'hD});
  assign w_is_load = w_op == 4'h4 && w_ext == 4'h0;
  assign w_is_stor = w_op == 4'h4 && w_ext == 4'h4;
  assign w_is_jump = w_op == 4'h4 && w_ext == 4'hC;
  assign w_is_br   = w_op == 4'hC;
  assign w_br_taken = w_is_br && ((w_rd == 4'h0 && r_flags[FZ]) ||
                                  (w_rd == 4'h1 && !r_flags[FZ]) ||
                                  (w_rd == 4'hE));

  // r0 is hardwired to zero on read; writes to it are dropped
  assign w_ra      = (w_rd == 4'h0) ? '0 : r_regs[w_rd];
  assign w_rb      = (w_rs == 4'h0) ? '0 : r_regs[w_rs];
  assign w_opb     = (w_op == 4'h0) ? r_b : r_imm;
  assign w_wb_data = w_is_load ? r_mdr : r_aluout;
  assign w_done    = run ? S_FETCH : S_IDLE;

  // ALU result and flag effects of the instruction in EXEC
  always_comb begin
    w_sum        = {1'b0, r_a} + {1'b0, w_opb};
    w_diff       = {1'b0, r_a} - {1'b0, w_opb};
    w_alu_res    = w_opb;
    w_flags_exec = r_flags;
    if (w_is_add) begin
      w_alu_res        = w_sum[WIDTH-1:0];
      w_flags_exec[FC] = w_sum[WIDTH];
      w_flags_exec[FF] = (r_a[WIDTH-1] == w_opb[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
    end else if (w_is_sub) begin
      w_alu_res        = w_diff[WIDTH-1:0];
      w_flags_exec[FC] = w_diff[WIDTH];
      w_flags_exec[FF] = (r_a[WIDTH-1] != w_opb[WIDTH-1]) && (w_diff[WIDTH-1] != r_a[WIDTH-1]);
    end else if (w_is_cmp) begin
      w_flags_exec[FZ] = r_a == w_opb;
      w_flags_exec[FL] = r_a < w_opb;
      w_flags_exec[FN] = $signed(r_a) < $signed(w_opb);
    end else if (w_op == 4'h0) begin
      case (w_ext)
        4'h1:    w_alu_res = r_a & r_b;
        4'h2:    w_alu_res = r_a | r_b;
        4'h3:    w_alu_res = r_a ^ r_b;
        default: w_alu_res = w_opb;
      endcase
    end
  end

  // Next state, pc, flags and ALU output
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_flags_nxt  = r_flags;
    w_aluout_nxt = r_aluout;
    w_rf_we      = 1'b0;
    case (r_state)
      S_IDLE:   if (run) w_state_nxt = S_FETCH;
      S_FETCH:  if (mem.mem_ack) begin
                  w_pc_nxt    = r_pc + WIDTH'(1);
                  w_state_nxt = S_DECODE;
                end
      S_DECODE: w_state_nxt = S_EXEC;
      S_EXEC: begin
        if (w_is_alu) begin
          w_aluout_nxt = w_alu_res;
          w_flags_nxt  = w_flags_exec;
          w_state_nxt  = S_WB;
        end else if (w_is_load || w_is_stor) begin
          w_state_nxt = S_MEM;
        end else begin
          w_flags_nxt = w_flags_exec;
          if (w_is_jump)       w_pc_nxt = r_b;
          else if (w_br_taken) w_pc_nxt = r_pc + r_imm;
          w_state_nxt = w_done;
        end
      end
      S_MEM:    if (mem.mem_ack) w_state_nxt = w_is_load ? S_WB : w_done;
      S_WB: begin
        w_rf_we     = 1'b1;
        w_state_nxt = w_done;
      end
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Datapath registers; memory outputs are registered from the next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc        <= '0;
      r_flags     <= '0;
      r_ir        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_imm       <= '0;
      r_aluout    <= '0;
      r_mdr       <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_pc     <= w_pc_nxt;
      r_flags  <= w_flags_nxt;
      r_aluout <= w_aluout_nxt;
      if (r_state == S_FETCH && mem.mem_ack) r_ir <= mem.mem_rdata[IW-1:0];
      if (r_state == S_DECODE) begin
        r_a   <= w_ra;
        r_b   <= w_rb;
        r_imm <= {{(WIDTH-8){r_ir[7]}}, r_ir[7:0]};
      end
      if (r_state == S_MEM && mem.mem_ack && w_is_load) r_mdr <= mem.mem_rdata;
      r_mem_req <= (w_state_nxt == S_FETCH) || (w_state_nxt == S_MEM);
      r_mem_we  <= (w_state_nxt == S_MEM) && w_is_stor;
      if (w_state_nxt == S_FETCH)    r_mem_addr <= w_pc_nxt;
      else if (w_state_nxt == S_MEM) r_mem_addr <= r_b;
      if (w_state_nxt == S_MEM) r_mem_wdata <= r_a;
    end
  end

  always_ff @(posedge clk) begin
    if (w_rf_we && w_rd != 4'h0) r_regs[w_rd] <= w_wb_data;
  end

  assign mem.mem_req   = r_mem_req;
  assign mem.mem_we    = r_mem_we;
  assign mem.mem_addr  = r_mem_addr;
  assign mem.mem_wdata = r_mem_wdata;
  assign pc            = r_pc;
  assign psr_flags     = r_flags;
  assign state         = 3'(r_state);

endmodule

// File: tb/tb_seq_datapath.sv
// Directed bench for seq_datapath: small programs run against a zero/multi-wait
// memory model, checking state sequence, bus values, flags and stores.
module tb_seq_datapath;

  localparam int unsigned WIDTH = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             run;
  logic             ack_en;
  logic [WIDTH-1:0] pc;
  logic [4:0]       psr_flags;
  logic [2:0]       state;
  logic [15:0]      mem_arr [64];
  int               wr_cnt = 0;
  logic [WIDTH-1:0] wr_data;
  int               n_checks = 0;
  int               n_errors = 0;
  int               cnt0;

  seq_datapath_if #(.WIDTH(WIDTH)) bus ();

  seq_datapath #(.WIDTH(WIDTH), .NREGS(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .mem       (bus),
    .pc        (pc),
    .psr_flags (psr_flags),
    .state     (state)
  );

  always #5 clk = ~clk;

  always_comb begin
    bus.mem_ack   = bus.mem_req && ack_en;
    bus.mem_rdata = mem_arr[bus.mem_addr[5:0]];
  end

  always @(posedge clk) begin
    if (bus.mem_req && bus.mem_we && bus.mem_ack) begin
      wr_cnt  <= wr_cnt + 1;
      wr_data <= bus.mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step_state(input string tag, input logic [2:0] exp);
    @(negedge clk);
    chk(tag, 32'(state), 32'(exp));
  endtask

  task automatic wait_state(input string tag, input logic [2:0] exp, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (state == exp) break;
    end
    chk(tag, 32'(state), 32'(exp));
  endtask

  task automatic wait_fetch(input string tag, input logic [WIDTH-1:0] addr, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (state == 3'd1 && bus.mem_addr == addr) break;
    end
    chk(tag, {13'd0, state, bus.mem_addr}, {13'd0, 3'd1, addr});
  endtask

  task automatic hold_reset();
    reset  = 1'b0;
    run    = 1'b0;
    ack_en = 1'b1;
    for (int i = 0; i < 64; i++) mem_arr[i] = 16'h0000;
    repeat (2) @(negedge clk);
  endtask

  task automatic release_run();
    run   = 1'b1;
    reset = 1'b1;
  endtask

  initial begin
    // Reset values, then MOVI r1,0x7F / ADDI r1,1 / STOR r1 -> M[r0]
    hold_reset();
    mem_arr[0] = 16'hD17F; mem_arr[1] = 16'h5101; mem_arr[2] = 16'h4140;
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_flags", 32'(psr_flags), 32'd0);
    chk("rst_req", 32'(bus.mem_req), 32'd0);
    release_run();
    step_state("a_fetch0", 3'd1);
    chk("a_addr0", 32'(bus.mem_addr), 32'd0);
    chk("a_req0", 32'(bus.mem_req), 32'd1);
    chk("a_we0", 32'(bus.mem_we), 32'd0);
    step_state("a_movi_dec", 3'd2);
    step_state("a_movi_exe", 3'd3);
    step_state("a_movi_wb", 3'd5);
    step_state("a_fetch1", 3'd1);
    chk("a_addr1", 32'(bus.mem_addr), 32'd1);
    step_state("a_addi_dec", 3'd2);
    step_state("a_addi_exe", 3'd3);
    step_state("a_addi_wb", 3'd5);
    step_state("a_fetch2", 3'd1);
    run = 1'b0;
    step_state("a_stor_dec", 3'd2);
    step_state("a_stor_exe", 3'd3);
    step_state("a_stor_mem", 3'd4);
    chk("a_stor_we", 32'(bus.mem_we), 32'd1);
    chk("a_stor_addr", 32'(bus.mem_addr), 32'd0);
    chk("a_stor_wdata", 32'(bus.mem_wdata), 32'h0080);
    step_state("a_idle", 3'd0);
    chk("a_wr_cnt", 32'(wr_cnt), 32'd1);
    chk("a_wr_data", 32'(wr_data), 32'h0080);
    chk("a_flags", 32'(psr_flags), 32'd0);
    step_state("a_idle_hold", 3'd0);
    chk("a_idle_req", 32'(bus.mem_req), 32'd0);

    // ADD carry: MOVI r2,0x80 (0xFF80) ; ADD r2,r2 ; STOR r2
    hold_reset();
    mem_arr[0] = 16'hD280; mem_arr[1] = 16'h0252; mem_arr[2] = 16'h4240;
    release_run();
    wait_state("b_mem", 3'd4, 40);
    chk("b_wdata", 32'(bus.mem_wdata), 32'hFF00);
    run = 1'b0;
    wait_state("b_idle", 3'd0, 10);
    chk("b_flags", 32'(psr_flags), 32'b00001);

    // Branch taken: CMPI r3,3 sets Z, BEQ -2 from address 4 refetches 3
    hold_reset();
    mem_arr[0] = 16'hD303; mem_arr[1] = 16'hB303; mem_arr[4] = 16'hC0FE;
    release_run();
    wait_fetch("c_fetch4", 16'd4, 40);
    chk("c_flags", 32'(psr_flags), 32'b01000);
    step_state("c_br_dec", 3'd2);
    step_state("c_br_exe", 3'd3);
    @(negedge clk);
    chk("c_target", {13'd0, state, bus.mem_addr}, {13'd0, 3'd1, 16'd3});
    chk("c_pc", 32'(pc), 32'd3);
    run = 1'b0;
    wait_state("c_idle", 3'd0, 10);

    // Branch not taken: CMPI r3,4 clears Z, sets L and N
    hold_reset();
    mem_arr[0] = 16'hD303; mem_arr[1] = 16'hB304; mem_arr[4] = 16'hC0FE;
    release_run();
    wait_fetch("d_fetch4", 16'd4, 40);
    chk("d_flags", 32'(psr_flags), 32'b10010);
    step_state("d_br_dec", 3'd2);
    step_state("d_br_exe", 3'd3);
    @(negedge clk);
    chk("d_fallthru", {13'd0, state, bus.mem_addr}, {13'd0, 3'd1, 16'd5});
    run = 1'b0;
    wait_state("d_idle", 3'd0, 10);

    // Wait states in FETCH hold the bus and pc
    hold_reset();
    mem_arr[0] = 16'hD105;
    ack_en = 1'b0;
    release_run();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("e_ws_state", 32'(state), 32'd1);
      chk("e_ws_pc", 32'(pc), 32'd0);
      chk("e_ws_addr", 32'(bus.mem_addr), 32'd0);
      chk("e_ws_req", 32'(bus.mem_req), 32'd1);
    end
    ack_en = 1'b1;
    step_state("e_decode", 3'd2);
    chk("e_pc", 32'(pc), 32'd1);
    run = 1'b0;
    wait_state("e_idle", 3'd0, 10);

    // Reset while STOR waits in MEM: request drops at once, no write
    hold_reset();
    mem_arr[0] = 16'h4140;
    release_run();
    wait_state("f_exec", 3'd3, 20);
    ack_en = 1'b0;
    step_state("f_mem", 3'd4);
    chk("f_mem_we", 32'(bus.mem_we), 32'd1);
    cnt0 = wr_cnt;
    #1 reset = 1'b0;
    #1;
    chk("f_req_drop", 32'(bus.mem_req), 32'd0);
    chk("f_we_drop", 32'(bus.mem_we), 32'd0);
    chk("f_state_rst", 32'(state), 32'd0);
    ack_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("f_no_write", 32'(wr_cnt), 32'(cnt0));
    release_run();
    step_state("f_restart", 3'd1);
    chk("f_restart_addr", 32'(bus.mem_addr), 32'd0);
    run = 1'b0;
    wait_state("f_idle", 3'd0, 20);

    // r0 discard, LOAD latency, STOR of loaded value, JUMP
    hold_reset();
    mem_arr[0] = 16'hD005; mem_arr[1] = 16'h4400; mem_arr[2] = 16'h4440;
    mem_arr[3] = 16'h4040; mem_arr[4] = 16'hD510; mem_arr[5] = 16'h45C5;
    release_run();
    step_state("g_fetch0", 3'd1);
    step_state("g_r0_dec", 3'd2);
    step_state("g_r0_exe", 3'd3);
    step_state("g_r0_wb", 3'd5);
    step_state("g_fetch1", 3'd1);
    step_state("g_ld_dec", 3'd2);
    step_state("g_ld_exe", 3'd3);
    step_state("g_ld_mem", 3'd4);
    chk("g_ld_we", 32'(bus.mem_we), 32'd0);
    chk("g_ld_addr", 32'(bus.mem_addr), 32'd0);
    step_state("g_ld_wb", 3'd5);
    step_state("g_fetch2", 3'd1);
    wait_state("g_st4_mem", 3'd4, 10);
    chk("g_st4_wdata", 32'(bus.mem_wdata), 32'hD005);
    wait_state("g_st0_mem", 3'd4, 10);
    chk("g_st0_wdata", 32'(bus.mem_wdata), 32'h0000);
    wait_fetch("g_fetch5", 16'd5, 20);
    step_state("g_jmp_dec", 3'd2);
    step_state("g_jmp_exe", 3'd3);
    @(negedge clk);
    chk("g_jmp_target", {13'd0, state, bus.mem_addr}, {13'd0, 3'd1, 16'h0010});
    run = 1'b0;
    wait_state("g_idle", 3'd0, 10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_datapath.md
SEQ_DATAPATH -- requirements
Module: seq_datapath

Interface
REQ-001 Parameter WIDTH, default 16, is the data, address and register width; legal range 16..32. Instruction word is fixed at 16 bits, taken from mem_rdata[15:0].
REQ-002 Parameter NREGS, default 16, is the register count, indexed by the 4-bit instruction fields; r0 always reads 0 and ignores writes.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port run, input, 1 bit: start enable, sampled only in IDLE and at instruction completion.
REQ-006 Port mem_req, output, 1 bit: memory request.
REQ-007 Port mem_we, output, 1 bit: write qualifier for mem_req.
REQ-008 Port mem_addr, output, WIDTH bits: memory address.
REQ-009 Port mem_wdata, output, WIDTH bits: store data.
REQ-010 Port mem_rdata, input, WIDTH bits: read data, valid when mem_ack=1.
REQ-011 Port mem_ack, input, 1 bit: memory completion.
REQ-012 Port pc, output, WIDTH bits: program counter.
REQ-013 Port psr_flags, output, 5 bits: {N,Z,F,L,C}.
REQ-014 Port state, output, 3 bits: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5.

Function
REQ-015 Instruction fields: op [15:12], rd [11:8], ext [7:4], rs [3:0], imm8 [7:0]; imm8 is sign-extended to WIDTH.
REQ-016 Opcodes:
- op 0 with ext 5/9/1/2/3/D/B = ADD/SUB/AND/OR/XOR/MOV/CMP rd,rs.
- op 5/9/D/B = ADDI/SUBI/MOVI/CMPI rd,imm.
- op 4 with ext 0 = LOAD rd<=M[rs]; ext 4 = STOR M[rs]<=rd; ext C = JUMP pc<=rs.
- op C = branch on cond rd (0 Z=1, 1 Z=0, E always) to pc+imm8.
- All other encodings are NOPs.
REQ-017 The FSM is multicycle and uses one memory port for both instructions and data.
REQ-018 IDLE: go to FETCH when run=1, else stay in IDLE.
REQ-019 FETCH: on mem_ack, latch IR, set pc<=pc+1 (wraps modulo 2^WIDTH), go to DECODE.
REQ-020 DECODE: latch A<=R[rd], B<=R[rs], and the extended immediate; go to EXEC.
REQ-021 EXEC, ALU ops: ALUOUT<=result, go to WB.
REQ-022 EXEC, CMP/CMPI/NOP/JUMP/branch: go to completion, with JUMP and taken-branch updating pc in this cycle.
REQ-023 EXEC, LOAD/STOR: go to MEM.
REQ-024 MEM: on mem_ack, LOAD latches MDR and goes to WB; STOR goes to completion.
REQ-025 WB: write ALUOUT or MDR to R[rd], then go to completion.
REQ-026 Completion goes to FETCH if run=1, else to IDLE.
REQ-027 mem_req=1 exactly in FETCH and MEM.
REQ-028 In FETCH: mem_addr=pc, mem_we=0.
REQ-029 In MEM: mem_addr=B, mem_we=1 only for STOR, mem_wdata=A.
REQ-030 All memory outputs hold stable while mem_ack=0; unlimited wait states are allowed.
REQ-031 mem_ack is ignored outside FETCH and MEM.
REQ-032 All arithmetic is modulo 2^WIDTH.
REQ-033 ADD/ADDI/SUB/SUBI update only C (carry-out or borrow) and F (signed overflow).
REQ-034 CMP/CMPI update only Z (A==B), L (A<B unsigned) and N (A<B signed).
REQ-035 All other instructions leave the flags unchanged.
REQ-036 A branch displacement is relative to the already-incremented pc.
REQ-037 A write to r0 is discarded but still consumes the WB cycle.
REQ-038 Latency with zero-wait memory:
- ALU ops: 4 cycles.
- CMP, branch and JUMP: 3 cycles.
- LOAD: 5 cycles.
- STOR: 4 cycles.

Reset
REQ-039 While reset=0, asynchronously force the outputs and internal state as follows:
- state=IDLE, pc=0, psr_flags=0, mem_req=0, mem_we=0.
- IR, A, B, ALUOUT and MDR = 0.
REQ-040 Register file contents are undefined after reset, except r0.
REQ-041 Reset mid-transaction drops mem_req in the same cycle.
REQ-042 Outstanding acks are not retried, and execution restarts from pc=0.

Verification
REQ-043 Scenario, reset: hold reset=0 -> pc=0, state=0, psr_flags=0, mem_req=0; release with run=1 -> FETCH at address 0 on the next edge.
REQ-044 Scenario, MOVI/ADDI/STOR: program 0xD17F, 0x5101, 0x4140 -> write to address 0 with data 0x0080; C=0, F=0; MOVI completes in 4 cycles.
REQ-045 Scenario, ADD carry: program 0xD280, 0x0252 -> r2=0xFF00, C=1, F=0.
REQ-046 Scenario, branch: MOVI r3,3; CMPI r3,3 (0xB303) -> Z=1, then 0xC0FE at address 4 -> next fetch at 3; with Z=0 -> next fetch at 5.
REQ-047 Scenario, wait states: mem_ack=0 for 3 cycles in FETCH -> state, pc, mem_addr and mem_req held constant; then ack -> DECODE.
REQ-048 Scenario, mid-MEM reset and run: reset=0 during STOR MEM -> mem_req=0 immediately, no write.
REQ-049 Scenario, run=0 at completion -> IDLE, with mem_req=0 until run=1.
